// File: rtl/alu_pg_seq.sv
// Power-gated multi-cycle integer ALU: single-cycle logic/arith ops, pipelined-latency multiply,
// iterative restoring divide, with abort on power loss or isolation and an output isolation clamp.
module alu_pg_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_en,
  input  logic             iso_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             err,
  output logic             abort,
  output logic             busy
);

  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned CntW = 7;
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;

  logic              kill;
  logic              ready_int;
  logic [WIDTH:0]    add_full;
  logic [WIDTH:0]    sub_full;
  logic [SH_W-1:0]   shamt;
  logic [WIDTH-1:0]  alu_lo, alu_hi;
  logic              alu_err;
  logic [2*WIDTH-1:0] prod_in, prod_q;
  logic [WIDTH:0]    rem_shift, rem_trial;
  logic [WIDTH-1:0]  rem_next, quo_next;

  assign kill      = !pwr_en || iso_en;
  assign ready_int = (state_q == StIdle) && !kill;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SH_W-1:0];
  assign prod_in  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign prod_q   = {{WIDTH{1'b0}}, op_a_q} * {{WIDTH{1'b0}}, op_b_q};

  // One restoring-division step: op_a_q shifts out dividend bits and shifts in quotient bits.
  assign rem_shift = {rem_q, op_a_q[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, op_b_q};
  assign rem_next  = rem_trial[WIDTH] ? rem_shift[WIDTH-1:0] : rem_trial[WIDTH-1:0];
  assign quo_next  = {op_a_q[WIDTH-2:0], ~rem_trial[WIDTH]};

  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    alu_err = 1'b0;
    case (opcode)
      4'h0: begin
        alu_lo = add_full[WIDTH-1:0];
        alu_hi = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
      end
      4'h1: begin
        alu_lo = sub_full[WIDTH-1:0];
        alu_hi = {{(WIDTH-1){1'b0}}, sub_full[WIDTH]};
      end
      4'h2: alu_lo = a & b;
      4'h3: alu_lo = a | b;
      4'h4: alu_lo = a ^ b;
      4'h5: alu_lo = ~(a | b);
      4'h6: alu_lo = a >> shamt;
      4'h7: alu_lo = ~(a ^ b);
      4'hA: alu_lo = a << shamt;
      4'hB: alu_lo = $signed(a) >>> shamt;
      4'hC: alu_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'h8, 4'h9: alu_err = 1'b0;  // handled by the sequencer
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rem_d       = rem_q;
    res_d       = res_q;
    res_hi_d    = res_hi_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    abort_d     = 1'b0;

    if (kill) begin
      // Power loss or isolation wins over everything; results are left untouched.
      if (state_q != StIdle) begin
        state_d = StIdle;
        cnt_d   = '0;
        abort_d = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_a_d = a;
            op_b_d = b;
            if (opcode == 4'h8) begin
              if (MUL_LAT == 1) begin
                {res_hi_d, res_d} = prod_in;
                out_valid_d       = 1'b1;
              end else begin
                state_d = StMul;
                cnt_d   = CntW'(1);
              end
            end else if (opcode == 4'h9) begin
              if (b == '0) begin
                res_d       = '1;
                res_hi_d    = a;
                err_d       = 1'b1;
                out_valid_d = 1'b1;
              end else begin
                state_d = StDiv;
                cnt_d   = '0;
                rem_d   = '0;
              end
            end else begin
              res_d       = alu_lo;
              res_hi_d    = alu_hi;
              err_d       = alu_err;
              out_valid_d = 1'b1;
            end
          end
        end
        StMul: begin
          if (cnt_q == MulLast) begin
            {res_hi_d, res_d} = prod_q;
            out_valid_d       = 1'b1;
            state_d           = StIdle;
            cnt_d             = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDiv: begin
          op_a_d = quo_next;
          rem_d  = rem_next;
          if (cnt_q == DivLast) begin
            res_d       = quo_next;
            res_hi_d    = rem_next;
            out_valid_d = 1'b1;
            state_d     = StIdle;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rem_q       <= '0;
      res_q       <= '0;
      res_hi_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rem_q       <= rem_d;
      res_q       <= res_d;
      res_hi_q    <= res_hi_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
    end
  end

  // Isolation clamp is combinational so it takes effect in the same cycle iso_en rises.
  assign in_ready  = ready_int;
  assign result    = iso_en ? '0 : res_q;
  assign result_hi = iso_en ? '0 : res_hi_q;
  assign out_valid = out_valid_q && !iso_en;
  assign err       = err_q && !iso_en;
  assign busy      = (state_q != StIdle) && !iso_en;
  assign abort     = abort_q;

endmodule

// File: tb/tb_alu_pg_seq.sv
// Self-checking bench for alu_pg_seq (WIDTH=16, MUL_LAT=5): vector table, random ops against an
// arithmetic reference model, and directed power/isolation/reset sequences.
module tb_alu_pg_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwr_en, iso_en, in_valid;
  logic        in_ready, out_valid, err, abort, busy;
  logic [15:0] a, b, result, result_hi;
  logic [3:0]  opcode;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pg_seq #(.WIDTH(16), .MUL_LAT(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_en    (pwr_en),
    .iso_en    (iso_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .result    (result),
    .result_hi (result_hi),
    .err       (err),
    .abort     (abort),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [3:0]  op;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic, latency in cycles from accept to out_valid.
  function automatic void model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] lo, output logic [15:0] hi,
                                output logic e, output int lat);
    longint ux, uy, p;
    int     sx, sy, sh;
    ux  = longint'(x);
    uy  = longint'(y);
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    sh  = int'(y % 16);
    lo  = '0;
    hi  = '0;
    e   = 1'b0;
    lat = 1;
    p   = 0;
    case (op)
      4'h0: begin p = ux + uy; lo = p[15:0]; hi = p[31:16]; end
      4'h1: begin p = ux - uy; lo = p[15:0]; hi = (ux < uy) ? 16'd1 : 16'd0; end
      4'h2: lo = x & y;
      4'h3: lo = x | y;
      4'h4: lo = x ^ y;
      4'h5: lo = ~(x | y);
      4'h6: begin p = ux / (longint'(1) << sh); lo = p[15:0]; end
      4'h7: lo = ~(x ^ y);
      4'h8: begin p = ux * uy; lo = p[15:0]; hi = p[31:16]; lat = 5; end
      4'h9: begin
        if (uy == 0) begin
          lo = 16'hFFFF; hi = x; e = 1'b1;
        end else begin
          p = ux / uy; lo = p[15:0];
          p = ux % uy; hi = p[15:0];
          lat = 17;
        end
      end
      4'hA: begin p = ux * (longint'(1) << sh); lo = p[15:0]; end
      4'hB: begin p = longint'(sx >>> sh); lo = p[15:0]; end
      4'hC: lo = (sx < sy) ? 16'd1 : 16'd0;
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one op from IDLE and wait for its completion strobe; samples on negedges.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [3:0] top,
                        output logic [15:0] lo, output logic [15:0] hi, output logic e,
                        output int lat, output int busy_n, output int rdy_viol);
    @(negedge clk);
    a = ta; b = tb_; opcode = top; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; busy_n = 0; rdy_viol = 0; lo = '0; hi = '0; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k; lo = result; hi = result_hi; e = err;
        break;
      end
      if (busy) busy_n++;
      if (in_ready) rdy_viol++;
    end
  endtask

  task automatic op_and_check(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                              input logic [3:0] top);
    logic [15:0] lo, hi, elo, ehi;
    logic        e, ee;
    int          lat, elat, bn, rv;
    model(top, ta, tb_, elo, ehi, ee, elat);
    run_op(ta, tb_, top, lo, hi, e, lat, bn, rv);
    check({name, ".lat"}, 64'(lat), 64'(elat));
    check({name, ".res"}, {hi, lo}, {ehi, elo});
    check({name, ".err"}, 64'(e), 64'(ee));
    check({name, ".busy"}, 64'(bn), 64'(elat - 1));
    check({name, ".ready"}, 64'(rv), 64'd0);
  endtask

  initial begin
    logic [15:0] lo, hi, ra, rb;
    logic [3:0]  rop;
    logic        e;
    int          lat, bn, rv, k, cnt_bad;

    rst_n = 1'b0; pwr_en = 1'b1; iso_en = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; opcode = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.result", 64'(result), 64'd0);
    check("reset.result_hi", 64'(result_hi), 64'd0);
    check("reset.flags", {out_valid, err, abort, busy}, 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);

    vecs.push_back('{16'hFFFF, 16'h0001, 4'h0, 16'h0000, 16'h0001, 1'b0, 1});
    vecs.push_back('{16'h8000, 16'h0004, 4'hB, 16'hF800, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'h0003, 16'h0005, 4'h1, 16'hFFFE, 16'h0001, 1'b0, 1});
    vecs.push_back('{16'hF0F0, 16'hFF00, 4'h2, 16'hF000, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'hF0F0, 16'h0F0F, 4'h3, 16'hFFFF, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'hFFFF, 16'h1234, 4'h4, 16'hEDCB, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'hF0F0, 16'h0F00, 4'h5, 16'h000F, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'h8000, 16'h001F, 4'h6, 16'h0001, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'h00FF, 16'h0F0F, 4'h7, 16'hF00F, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'h0001, 16'h0004, 4'hA, 16'h0010, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'hFFFF, 16'h0001, 4'hC, 16'h0001, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'h0005, 16'hFFFE, 4'hC, 16'h0000, 16'h0000, 1'b0, 1});
    vecs.push_back('{16'h1234, 16'h5678, 4'h8, 16'h0060, 16'h0626, 1'b0, 5});
    vecs.push_back('{16'd1000, 16'd7,    4'h9, 16'd142,  16'd6,    1'b0, 17});
    vecs.push_back('{16'h00AB, 16'h0000, 4'h9, 16'hFFFF, 16'h00AB, 1'b1, 1});
    vecs.push_back('{16'h1111, 16'h2222, 4'hE, 16'h0000, 16'h0000, 1'b1, 1});
    vecs.push_back('{16'h1111, 16'h2222, 4'hD, 16'h0000, 16'h0000, 1'b1, 1});
    vecs.push_back('{16'hFFFF, 16'h0001, 4'h9, 16'hFFFF, 16'h0000, 1'b0, 17});

    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].op, lo, hi, e, lat, bn, rv);
      check($sformatf("vec%0d.lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d.res", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d.err", i), 64'(e), 64'(vecs[i].e));
      check($sformatf("vec%0d.busy", i), 64'(bn), 64'(vecs[i].lat - 1));
      check($sformatf("vec%0d.ready", i), 64'(rv), 64'd0);
    end

    for (int i = 0; i < 120; i++) begin
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      op_and_check($sformatf("rnd%0d_op%0h", i, rop), ra, rb, rop);
    end

    // Back-to-back: new accept in the cycle out_valid is high.
    @(negedge clk);
    a = 16'd1; b = 16'd1; opcode = 4'h0; in_valid = 1'b1;
    @(posedge clk);
    #1 a = 16'h00F0; b = 16'h0F00; opcode = 4'h4;
    @(negedge clk);
    check("b2b.first", {out_valid, in_ready, result}, {1'b1, 1'b1, 16'd2});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b.second", {out_valid, result}, {1'b1, 16'h0FF0});

    // Power drop on the 5th busy cycle of a divide.
    op_and_check("pre_abort_or", 16'h1200, 16'h0034, 4'h3);
    @(negedge clk);
    a = 16'd1000; b = 16'd7; opcode = 4'h9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) k++;
      if (k == 5) begin pwr_en = 1'b0; break; end
    end
    check("pwr.busy_reached", 64'(k), 64'd5);
    @(negedge clk);
    check("pwr.abort", {abort, busy, out_valid}, {1'b1, 1'b0, 1'b0});
    check("pwr.result_held", {result_hi, result}, {16'h0000, 16'h1234});
    cnt_bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (abort || out_valid || busy) cnt_bad++;
    end
    check("pwr.quiet_after", 64'(cnt_bad), 64'd0);
    pwr_en = 1'b1;
    op_and_check("pwr.resume_add", 16'd2, 16'd3, 4'h0);

    // Isolation during IDLE: clamp and ignore in_valid.
    op_and_check("pre_iso_or", 16'h1200, 16'h0034, 4'h3);
    @(negedge clk);
    iso_en = 1'b1;
    #1;
    check("iso.clamp", {result, result_hi, in_ready, busy, out_valid, err}, 64'd0);
    a = 16'd9; b = 16'd9; opcode = 4'h0; in_valid = 1'b1;
    cnt_bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid || busy || abort || in_ready || result != 16'h0) cnt_bad++;
    end
    check("iso.ignored", 64'(cnt_bad), 64'd0);
    in_valid = 1'b0;
    iso_en = 1'b0;
    #1;
    check("iso.release", {result_hi, result}, {16'h0000, 16'h1234});

    // Isolation while busy in a multiply: abort is not clamped.
    @(negedge clk);
    a = 16'd100; b = 16'd100; opcode = 4'h8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("iso_mul.busy", 64'(busy), 64'd1);
    iso_en = 1'b1;
    @(negedge clk);
    check("iso_mul.abort", {abort, busy, out_valid, result}, {1'b1, 1'b0, 1'b0, 16'h0});
    iso_en = 1'b0;
    repeat (8) @(negedge clk);
    check("iso_mul.held", {result_hi, result, out_valid}, {16'h0000, 16'h1234, 1'b0});

    // Reset mid-multiply: outputs return to reset values immediately, no abort.
    @(negedge clk);
    a = 16'h00FF; b = 16'h00FF; opcode = 4'h8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs", {result, result_hi, out_valid, err, abort, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (abort || out_valid || busy) cnt_bad++;
    end
    check("rst_mid.quiet", 64'(cnt_bad), 64'd0);
    op_and_check("post_rst_mul", 16'h1234, 16'h5678, 4'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
